// File: rtl/req_outstanding_tracker.sv
// Caps in-flight requests and tags each returning response with the {we, addr} of the request it answers.
// Build option: define REQ_TRACK_ERR_STICKY_EN to hold err_o until reset instead of pulsing it.
module req_outstanding_tracker #(
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                req_i,
  output logic                                gnt_o,
  input  logic                                we_i,
  input  logic [AW-1:0]                       addr_i,
  input  logic [DW-1:0]                       data_i,
  input  logic [DW/8-1:0]                     be_i,
  output logic                                r_valid_o,
  output logic                                r_we_o,
  output logic [AW-1:0]                       r_addr_o,
  output logic                                req_o,
  input  logic                                gnt_i,
  output logic                                we_o,
  output logic [AW-1:0]                       addr_o,
  output logic [DW-1:0]                       data_o,
  output logic [DW/8-1:0]                     be_o,
  input  logic                                r_valid_i,
  output logic [$clog2(NumOutstanding+1)-1:0] outstanding_o,
  output logic                                full_o,
  output logic                                err_o
);

  localparam int unsigned CW = $clog2(NumOutstanding + 1);
  localparam int unsigned PW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_we_q   [NumOutstanding];
  logic [AW-1:0] fifo_addr_q [NumOutstanding];
  logic          err_q;

  logic full, empty, push, pop, spurious;

  assign full     = (count_q == CW'(NumOutstanding));
  assign empty    = (count_q == '0);
  assign push     = req_o & gnt_i;
  assign pop      = r_valid_i & ~empty;
  // A response with nothing tracked is spurious even if a grant lands in the same cycle.
  assign spurious = r_valid_i & empty;

  assign req_o  = req_i & ~full;
  assign gnt_o  = gnt_i & req_o;
  assign we_o   = we_i;
  assign addr_o = addr_i;
  assign data_o = data_i;
  assign be_o   = be_i;

  assign r_valid_o     = pop;
  assign r_we_o        = empty ? 1'b0 : fifo_we_q[rd_ptr_q];
  assign r_addr_o      = empty ? '0   : fifo_addr_q[rd_ptr_q];
  assign outstanding_o = count_q;
  assign full_o        = full;
  assign err_o         = err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NumOutstanding - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(NumOutstanding); i++) begin
        fifo_we_q[i]   <= 1'b0;
        fifo_addr_q[i] <= '0;
      end
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) begin
        fifo_we_q[wr_ptr_q]   <= we_i;
        fifo_addr_q[wr_ptr_q] <= addr_i;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
`ifdef REQ_TRACK_ERR_STICKY_EN
      err_q <= err_q | spurious;
`else
      err_q <= spurious;
`endif
    end
  end

endmodule

// File: tb/tb_req_outstanding_tracker.sv
// Scoreboard bench: a queue model of in-flight requests predicts grants, tags and errors.
module tb_req_outstanding_tracker;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = $clog2(N + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            req_i, gnt_o, we_i;
  logic [AW-1:0]   addr_i;
  logic [DW-1:0]   data_i;
  logic [DW/8-1:0] be_i;
  logic            r_valid_o, r_we_o;
  logic [AW-1:0]   r_addr_o;
  logic            req_o, gnt_i, we_o;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   data_o;
  logic [DW/8-1:0] be_o;
  logic            r_valid_i;
  logic [CW-1:0]   outstanding_o;
  logic            full_o, err_o;

  req_outstanding_tracker #(.NumOutstanding(N), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i), .data_i(data_i), .be_i(be_i),
    .r_valid_o(r_valid_o), .r_we_o(r_we_o), .r_addr_o(r_addr_o),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .be_o(be_o),
    .r_valid_i(r_valid_i), .outstanding_o(outstanding_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  logic [AW:0] model_q[$];  // outstanding requests, {we, addr}, oldest first
  logic [AW:0] exp_q[$];    // responses the DUT must present, in order
  logic        err_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented response must match the next expected tag.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (r_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rvalid: got r_valid_o=1 expected 0 at %0t", $time);
        end else begin
          logic [AW:0] e;
          e = exp_q.pop_front();
          check("resp_we", 64'(r_we_o), 64'(e[AW]));
          check("resp_addr", 64'(r_addr_o), 64'(e[AW-1:0]));
        end
      end
      if (exp_q.size() != 0) begin
        tests++; fails++;
        $display("FAIL missing_rvalid: got r_valid_o=%0b expected 1 at %0t", r_valid_o, $time);
        exp_q.delete();
      end
    end
  end

  // One clock cycle: drive inputs, check combinational outputs against the model, then advance it.
  task automatic step(input logic rq, input logic we, input logic [AW-1:0] a, input logic g,
                      input logic rv);
    logic exp_req, exp_gnt, popped, spur;
    logic [AW:0] head;
    logic [DW-1:0] d;
    d = $urandom;
    req_i = rq; we_i = we; addr_i = a; gnt_i = g; r_valid_i = rv;
    data_i = d; be_i = 4'($urandom);
    #1;
    exp_req = rq && (model_q.size() < N);
    exp_gnt = g && exp_req;
    head    = (model_q.size() > 0) ? model_q[0] : '0;
    check("req_o", 64'(req_o), 64'(exp_req));
    check("gnt_o", 64'(gnt_o), 64'(exp_gnt));
    check("full_o", 64'(full_o), 64'(model_q.size() == N));
    check("outstanding_o", 64'(outstanding_o), 64'(model_q.size()));
    check("err_o", 64'(err_o), 64'(err_m));
    check("head_we", 64'(r_we_o), 64'(head[AW]));
    check("head_addr", 64'(r_addr_o), 64'(head[AW-1:0]));
    check("passthru", {we_o, addr_o, data_o[30:0]}, {we, a, d[30:0]});
    popped = rv && (model_q.size() > 0);
    spur   = rv && (model_q.size() == 0);
    if (popped) exp_q.push_back(head);
    @(posedge clk_i);
    if (popped) void'(model_q.pop_front());
    if (exp_gnt) model_q.push_back({we, a});
`ifdef REQ_TRACK_ERR_STICKY_EN
    err_m = err_m | spur;
`else
    err_m = spur;
`endif
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (model_q.size() > 0) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt_o", 64'(gnt_o), 64'd0);
    check("rst_req_o", 64'(req_o), 64'd0);
    check("rst_r_valid_o", 64'(r_valid_o), 64'd0);
    check("rst_full_o", 64'(full_o), 64'd0);
    check("rst_err_o", 64'(err_o), 64'd0);
    check("rst_outstanding_o", 64'(outstanding_o), 64'd0);
    check("rst_r_tag", {r_we_o, r_addr_o}, 64'd0);
  endtask

  task automatic do_reset();
    req_i = 0; we_i = 0; addr_i = '0; data_i = '0; be_i = '0; gnt_i = 0; r_valid_i = 0;
    rst_ni = 1'b0;
    #2;
    check_reset_outputs();
    model_q.delete(); exp_q.delete(); err_m = 1'b0;
    @(posedge clk_i); #1;
    check_reset_outputs();
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    rst_ni = 1'b1;
    err_m  = 1'b0;
    #3;
    do_reset();
    idle(1);

    // Single read
    step(1, 0, 32'h100, 1, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    idle(1);

    // Fill, stall while full, reassert after one response
    step(1, 1, 32'h10, 1, 0);
    step(1, 1, 32'h14, 1, 0);
    step(1, 1, 32'h18, 1, 0);
    step(1, 1, 32'h1C, 1, 0);
    step(1, 1, 32'h1C, 1, 1);
    step(1, 1, 32'h1C, 0, 0);
    drain();

    // Simultaneous push and pop at count 1
    step(1, 0, 32'h1C, 1, 0);
    step(1, 0, 32'h20, 1, 1);
    step(0, 0, '0, 0, 0);
    drain();

    // Spurious response, including one coinciding with a grant
    step(0, 0, '0, 0, 1);
    idle(2);
    step(1, 0, 32'h40, 1, 1);
    step(0, 0, '0, 0, 0);
    drain();
    idle(1);

    // Pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(1, 0, AW'(4 * i), 1, 0);
      step(0, 0, '0, 0, 1);
    end
    idle(1);

    do_reset();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom) & ~32'h3,
           1'($urandom), ($urandom_range(0, 9) < 4));
    end
    drain();

    // Reset with two outstanding, then a late response
    do_reset();
    step(1, 0, 32'h200, 1, 0);
    step(1, 1, 32'h204, 1, 0);
    #2;
    do_reset();
    step(0, 0, '0, 0, 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
